// File: rtl/rrd_issue_buffer_if.sv
// Uop bundle type and the dispatch / issue / branch-update interface
// for rrd_issue_buffer. Modport slave is the buffer, master its neighbours.
package rrd_issue_buffer_pkg;
  typedef struct packed {
    logic [6:0]  uopc;
    logic [9:0]  fu_code;
    logic [19:0] br_mask;
    logic [19:0] imm_packed;
    logic [6:0]  rob_idx;
    logic [4:0]  stq_idx;
    logic [6:0]  pdst;
    logic [4:0]  mem_cmd;
    logic        is_amo;
    logic        uses_ldq;
    logic        uses_stq;
    logic [1:0]  dst_rtype;
    logic        fp_val;
  } uop_t;
endpackage

interface rrd_issue_buffer_if
  import rrd_issue_buffer_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
);
  logic             io_dis_valid;
  logic             io_dis_ready;
  uop_t             io_dis_uop;
  logic             io_iss_valid;
  logic             io_iss_ready;
  uop_t             io_iss_uop;
  logic [19:0]      io_brupdate_resolve_mask;
  logic [19:0]      io_brupdate_mispredict_mask;
  logic             io_flush;
  logic [CNT_W-1:0] io_count;

  modport slave (
    input  io_dis_valid,
    input  io_dis_uop,
    input  io_iss_ready,
    input  io_brupdate_resolve_mask,
    input  io_brupdate_mispredict_mask,
    input  io_flush,
    output io_dis_ready,
    output io_iss_valid,
    output io_iss_uop,
    output io_count
  );

  modport master (
    output io_dis_valid,
    output io_dis_uop,
    output io_iss_ready,
    output io_brupdate_resolve_mask,
    output io_brupdate_mispredict_mask,
    output io_flush,
    input  io_dis_ready,
    input  io_iss_valid,
    input  io_iss_uop,
    input  io_count
  );
endinterface

// File: rtl/rrd_issue_buffer.sv
// In-order issue buffer feeding register-read decode.
// Ports: clock, reset (sync, high), io (rrd_issue_buffer_if.slave):
//   dis_* in, iss_* out, brupdate masks, flush, count.
// Optional same-cycle bypass when empty: define RRD_ISSUE_BYPASS_EN.
module rrd_issue_buffer
  import rrd_issue_buffer_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  rrd_issue_buffer_if.slave  io
);

  localparam int PW = $clog2(ENTRIES);

  uop_t             mem [ENTRIES];
  logic [ENTRIES-1:0] vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CNT_W-1:0] count;

  logic [19:0] rs;
  logic [19:0] mp;
  uop_t        hd;
  uop_t        dis_m;
  logic        occ;
  logic        hd_kill;
  logic        dis_kill;
  logic        hd_ok;
  logic        byp;
  logic        enq;
  logic        wr;
  logic        deq;

  assign rs = io.io_brupdate_resolve_mask;
  assign mp = io.io_brupdate_mispredict_mask;
  assign io.io_count = count;

  always_comb begin
    hd = mem[head];
    hd.br_mask = mem[head].br_mask & ~rs;
    dis_m = io.io_dis_uop;
    dis_m.br_mask = io.io_dis_uop.br_mask & ~rs;
    occ = (count != '0);
    hd_kill = |(mem[head].br_mask & mp);
    dis_kill = |(io.io_dis_uop.br_mask & mp);
    hd_ok = occ & vld[head] & ~hd_kill;
`ifdef RRD_ISSUE_BYPASS_EN
    byp = ~occ & io.io_dis_valid & io.io_iss_ready
        & ~io.io_flush & ~dis_kill;
`else
    byp = 1'b0;
`endif
    // ready looks only at registered count
    io.io_dis_ready = (count != CNT_W'(ENTRIES));
    enq = io.io_dis_valid & io.io_dis_ready;
    wr = enq & ~byp;
    io.io_iss_valid = hd_ok | byp;
    io.io_iss_uop = byp ? dis_m : hd;
    // dead head slots drain silently, one per cycle
    deq = (hd_ok & io.io_iss_ready) | (occ & ~vld[head]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < ENTRIES; i++)
        mem[i] <= '0;
    end else if (io.io_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].br_mask <= mem[i].br_mask & ~rs;
        if (|(mem[i].br_mask & mp))
          vld[i] <= 1'b0;
      end
      if (wr) begin
        mem[tail] <= dis_m;
        vld[tail] <= ~dis_kill;
        tail      <= tail + PW'(1);
      end
      if (deq)
        head <= head + PW'(1);
      count <= count + CNT_W'(wr) - CNT_W'(deq);
    end
  end

endmodule

// File: tb/tb_rrd_issue_buffer.sv
// Directed bench for rrd_issue_buffer.
// Linear step sequence with immediate assertions.
module tb_rrd_issue_buffer;
  import rrd_issue_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rrd_issue_buffer_if #(.ENTRIES(8)) io ();

  rrd_issue_buffer #(.ENTRIES(8)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic uop_t mk(input logic [6:0] rob,
                              input logic [19:0] br);
    uop_t u;
    u = '0;
    u.uopc = rob ^ 7'h55;
    u.fu_code = 10'h3;
    u.br_mask = br;
    u.imm_packed = {13'h0, rob};
    u.rob_idx = rob;
    u.pdst = rob + 7'd1;
    u.dst_rtype = 2'd1;
    return u;
  endfunction

  task automatic push(input logic [6:0] rob,
                      input logic [19:0] br);
    io.io_dis_valid = 1'b1;
    io.io_dis_uop = mk(rob, br);
    tick();
    io.io_dis_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    io.io_dis_valid = 1'b0;
    io.io_dis_uop = '0;
    io.io_iss_ready = 1'b0;
    io.io_brupdate_resolve_mask = '0;
    io.io_brupdate_mispredict_mask = '0;
    io.io_flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_iss_valid", io.io_iss_valid, 0);
    chk("rst_dis_ready", io.io_dis_ready, 1);
    chk("rst_count", io.io_count, 0);
    chk("rst_uop_rob", io.io_iss_uop.rob_idx, 0);
    chk("rst_uop_br", io.io_iss_uop.br_mask, 0);
    tick();
    chk("idle_iss_valid", io.io_iss_valid, 0);

    for (int i = 0; i < 8; i++) begin
      io.io_dis_valid = 1'b1;
      io.io_dis_uop = mk(7'(i), 20'h0);
      #1;
      chk("fill_ready", io.io_dis_ready, 1);
      tick();
    end
    io.io_dis_valid = 1'b0;
    #1;
    chk("full_count", io.io_count, 8);
    chk("full_ready", io.io_dis_ready, 0);
    chk("full_iss_valid", io.io_iss_valid, 1);
    io.io_iss_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_valid", io.io_iss_valid, 1);
      chk("drain_rob", io.io_iss_uop.rob_idx, i);
      chk("drain_pdst", io.io_iss_uop.pdst, i + 1);
      chk("drain_count", io.io_count, 8 - i);
      tick();
    end
    chk("drained_count", io.io_count, 0);
    chk("drained_valid", io.io_iss_valid, 0);
    io.io_iss_ready = 1'b0;

    push(7'd40, 20'h00003);
    chk("res_pre_br", io.io_iss_uop.br_mask, 20'h00003);
    io.io_brupdate_resolve_mask = 20'h00001;
    #1;
    chk("res_comb_br", io.io_iss_uop.br_mask, 20'h00002);
    tick();
    io.io_brupdate_resolve_mask = '0;
    #1;
    chk("res_stored_br", io.io_iss_uop.br_mask, 20'h00002);
    io.io_iss_ready = 1'b1;
    tick();
    io.io_iss_ready = 1'b0;
    chk("res_pop_count", io.io_count, 0);

    io.io_brupdate_resolve_mask = 20'h00001;
    push(7'd41, 20'h00003);
    io.io_brupdate_resolve_mask = '0;
    #1;
    chk("res_disp_br", io.io_iss_uop.br_mask, 20'h00002);
    chk("res_disp_rob", io.io_iss_uop.rob_idx, 41);
    io.io_iss_ready = 1'b1;
    tick();
    io.io_iss_ready = 1'b0;

    push(7'd10, 20'h0);
    push(7'd11, 20'h00004);
    push(7'd12, 20'h0);
    io.io_brupdate_mispredict_mask = 20'h00004;
    #1;
    chk("kill_a_valid", io.io_iss_valid, 1);
    chk("kill_a_rob", io.io_iss_uop.rob_idx, 10);
    tick();
    io.io_brupdate_mispredict_mask = '0;
    io.io_iss_ready = 1'b1;
    #1;
    chk("kill_a_issue", io.io_iss_uop.rob_idx, 10);
    tick();
    chk("kill_b_hidden", io.io_iss_valid, 0);
    chk("kill_b_count", io.io_count, 2);
    tick();
    chk("kill_c_valid", io.io_iss_valid, 1);
    chk("kill_c_rob", io.io_iss_uop.rob_idx, 12);
    chk("kill_c_count", io.io_count, 1);
    tick();
    chk("kill_end_count", io.io_count, 0);
    io.io_iss_ready = 1'b0;

    io.io_brupdate_mispredict_mask = 20'h00008;
    push(7'd13, 20'h00008);
    io.io_brupdate_mispredict_mask = '0;
    #1;
    chk("dkill_count", io.io_count, 1);
    chk("dkill_valid", io.io_iss_valid, 0);
    tick();
    chk("dkill_popped", io.io_count, 0);

    for (int i = 0; i < 5; i++)
      push(7'(50 + i), 20'h0);
    chk("fl_pre_count", io.io_count, 5);
    io.io_flush = 1'b1;
    io.io_dis_valid = 1'b1;
    io.io_dis_uop = mk(7'd60, 20'h0);
    tick();
    io.io_flush = 1'b0;
    io.io_dis_valid = 1'b0;
    #1;
    chk("fl_count", io.io_count, 0);
    chk("fl_iss_valid", io.io_iss_valid, 0);
    chk("fl_dis_ready", io.io_dis_ready, 1);
    tick();
    chk("fl_no_enq", io.io_count, 0);

    for (int i = 0; i < 8; i++)
      push(7'(i), 20'h0);
    io.io_iss_ready = 1'b1;
    io.io_dis_valid = 1'b1;
    io.io_dis_uop = mk(7'd20, 20'h0);
    #1;
    chk("fd_ready", io.io_dis_ready, 0);
    chk("fd_valid", io.io_iss_valid, 1);
    tick();
    io.io_dis_valid = 1'b0;
    io.io_iss_ready = 1'b0;
    #1;
    chk("fd_count", io.io_count, 7);
    io.io_iss_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      #1;
      chk("fd_rob", io.io_iss_uop.rob_idx, i);
      tick();
    end
    chk("fd_end_count", io.io_count, 0);
    chk("fd_end_valid", io.io_iss_valid, 0);

    io.io_dis_valid = 1'b1;
    io.io_dis_uop = mk(7'd30, 20'h00005);
    io.io_brupdate_resolve_mask = 20'h00001;
    #1;
`ifdef RRD_ISSUE_BYPASS_EN
    chk("byp_valid", io.io_iss_valid, 1);
    chk("byp_rob", io.io_iss_uop.rob_idx, 30);
    chk("byp_br", io.io_iss_uop.br_mask, 20'h00004);
    tick();
    io.io_dis_valid = 1'b0;
    io.io_brupdate_resolve_mask = '0;
    #1;
    chk("byp_count", io.io_count, 0);
`else
    chk("nobyp_valid", io.io_iss_valid, 0);
    tick();
    io.io_dis_valid = 1'b0;
    io.io_brupdate_resolve_mask = '0;
    #1;
    chk("nobyp_count", io.io_count, 1);
    chk("nobyp_rob", io.io_iss_uop.rob_idx, 30);
    chk("nobyp_br", io.io_iss_uop.br_mask, 20'h00004);
    tick();
    chk("nobyp_pop", io.io_count, 0);
`endif
    io.io_iss_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
